// File: rtl/ibex_multdiv_arbiter.sv
//==============================================================================
// Module  : ibex_multdiv_arbiter
// Purpose : Round-robin sharing of one iterative mult/div unit between requesters.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module ibex_multdiv_arbiter #(
  parameter int NumReq     = 2,
  parameter int TimeoutCyc = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  input  logic [NumReq-1:0]      req_is_div_i,
  input  logic [2*NumReq-1:0]    req_operator_i,
  input  logic [2*NumReq-1:0]    req_signed_i,
  input  logic [32*NumReq-1:0]   req_op_a_i,
  input  logic [32*NumReq-1:0]   req_op_b_i,
  input  logic [NumReq-1:0]      flush_i,
  output logic [NumReq-1:0]      rsp_valid_o,
  input  logic [NumReq-1:0]      rsp_ready_i,
  output logic [31:0]            rsp_result_o,
  output logic                   rsp_err_o,
  output logic                   md_mult_en_o,
  output logic                   md_div_en_o,
  output logic [1:0]             md_operator_o,
  output logic [1:0]             md_signed_o,
  output logic [31:0]            md_op_a_o,
  output logic [31:0]            md_op_b_o,
  output logic                   md_ready_id_o,
  input  logic                   md_valid_i,
  input  logic [31:0]            md_result_i,
  output logic                   busy_o
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(TimeoutCyc + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [IdxW-1:0]   rr_ptr, owner;
  logic [CntW-1:0]   cnt;
  logic              is_div, err;
  logic [1:0]        op_sel, sgn;
  logic [31:0]       op_a, op_b, result;

  logic [IdxW-1:0]   win, cand;
  logic              found;
  logic              sel_div;
  logic [1:0]        sel_oper, sel_sgn;
  logic [31:0]       sel_a, sel_b;
  logic              own_flush, timeout, in_busy;

  // Round-robin search starting just after the last winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = rr_ptr;
    for (int k = 0; k < NumReq; k++) begin
      cand = (cand == IdxW'(NumReq - 1)) ? '0 : cand + IdxW'(1);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    sel_div  = 1'b0;
    sel_oper = '0;
    sel_sgn  = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (win == IdxW'(i)) begin
        sel_div  = req_is_div_i[i];
        sel_oper = req_operator_i[2*i +: 2];
        sel_sgn  = req_signed_i[2*i +: 2];
        sel_a    = req_op_a_i[32*i +: 32];
        sel_b    = req_op_b_i[32*i +: 32];
      end
    end
  end

  assign own_flush = flush_i[owner];
  assign timeout   = (cnt == CntW'(TimeoutCyc - 1));
  assign in_busy   = (state == BUSY);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (found) state_nxt = BUSY;
      BUSY: begin
        if (own_flush)                  state_nxt = IDLE;
        else if (md_valid_i || timeout) state_nxt = RESP;
      end
      RESP: if (own_flush || rsp_ready_i[owner]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= IdxW'(NumReq - 1);
      owner  <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
      op_sel <= '0;
      sgn    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner  <= win;
            rr_ptr <= win;
            cnt    <= '0;
            is_div <= sel_div;
            op_sel <= sel_oper;
            sgn    <= sel_sgn;
            op_a   <= sel_a;
            op_b   <= sel_b;
          end
        end
        BUSY: begin
          cnt <= cnt + CntW'(1);
          if (!own_flush) begin
            if (md_valid_i) begin
              result <= md_result_i;
              err    <= 1'b0;
            end else if (timeout) begin
              result <= '0;
              err    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // The grant is gated by reset so that every output is zero while reset is held.
  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (state == IDLE && found && !rst_i) req_ready_o[win] = 1'b1;
    if (state == RESP) rsp_valid_o[owner] = 1'b1;
  end

  assign rsp_result_o  = (state == RESP) ? result : '0;
  assign rsp_err_o     = (state == RESP) && err;
  assign md_mult_en_o  = in_busy && !is_div;
  assign md_div_en_o   = in_busy && is_div;
  assign md_ready_id_o = in_busy;
  assign md_operator_o = in_busy ? op_sel : '0;
  assign md_signed_o   = in_busy ? sgn : '0;
  assign md_op_a_o     = in_busy ? op_a : '0;
  assign md_op_b_o     = in_busy ? op_b : '0;
  assign busy_o        = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ibex_multdiv_arbiter.sv
//==============================================================================
// Module  : tb_ibex_multdiv_arbiter
// Purpose : Scoreboard bench for the shared mult/div arbiter with a unit model.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_ibex_multdiv_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_is_div, flush, rsp_valid, rsp_ready;
  logic [3:0]  req_operator, req_signed;
  logic [63:0] req_op_a, req_op_b;
  logic [31:0] rsp_result, md_op_a, md_op_b, md_result;
  logic        rsp_err, md_mult_en, md_div_en, md_ready_id, md_valid, busy;
  logic [1:0]  md_operator, md_signed;

  ibex_multdiv_arbiter #(.NumReq(2), .TimeoutCyc(64)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_is_div_i(req_is_div),
    .req_operator_i(req_operator), .req_signed_i(req_signed),
    .req_op_a_i(req_op_a), .req_op_b_i(req_op_b), .flush_i(flush),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
    .md_mult_en_o(md_mult_en), .md_div_en_o(md_div_en),
    .md_operator_o(md_operator), .md_signed_o(md_signed),
    .md_op_a_o(md_op_a), .md_op_b_o(md_op_b), .md_ready_id_o(md_ready_id),
    .md_valid_i(md_valid), .md_result_i(md_result), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] res;
    logic        err;
  } rsp_t;

  rsp_t       rsp_q[$];
  logic [1:0] grant_q[$];
  int checks = 0;
  int errors = 0;

  // Unit model: md_lat enabled cycles then one-cycle valid; hang suppresses valid.
  int md_lat = 1;
  bit hang   = 1'b0;
  int ucnt   = 0;

  // Snapshot of DUT outputs taken mid-cycle by cycle()
  logic [1:0]  s_ready, s_rsp_valid, s_oper;
  logic [31:0] s_result, s_op_a, s_op_b;
  logic        s_err, s_mult, s_div, s_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    md_valid  = 1'b0;
    md_result = '0;
    forever begin
      @(negedge clk);
      if ((md_mult_en || md_div_en) && !hang) begin
        if (ucnt == md_lat - 1) begin
          md_valid = 1'b1;
          if (md_div_en) md_result = (md_operator == 2'd2) ? md_op_a / md_op_b : md_op_a % md_op_b;
          else           md_result = md_op_a * md_op_b;
        end else begin
          md_valid = 1'b0;
        end
        ucnt++;
      end else begin
        ucnt     = 0;
        md_valid = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on every grant and every response handshake.
  logic [1:0] mon_g;
  rsp_t       mon_e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (req_ready != 2'b00) begin
          if (grant_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected: got %b, expected no grant", req_ready);
          end else begin
            mon_g = grant_q.pop_front();
            chk("grant", {30'd0, req_ready}, {30'd0, mon_g});
          end
        end
        if ((rsp_valid & rsp_ready) != 2'b00) begin
          if (rsp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected: got valid %b result 0x%0h, expected none", rsp_valid, rsp_result);
          end else begin
            mon_e = rsp_q.pop_front();
            chk("rsp_id", {30'd0, rsp_valid}, {30'd0, mon_e.id});
            chk("rsp_result", rsp_result, mon_e.res);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, mon_e.err});
          end
        end
      end
    end
  end

  task automatic cycle();
    logic [1:0] r;
    @(negedge clk);
    r = req_ready;
    s_ready = r; s_rsp_valid = rsp_valid; s_result = rsp_result; s_err = rsp_err;
    s_mult = md_mult_en; s_div = md_div_en; s_busy = busy;
    s_op_a = md_op_a; s_op_b = md_op_b; s_oper = md_operator;
    @(posedge clk); #1;
    req_valid = req_valid & ~r;
  endtask

  task automatic load(input int id, input bit dv, input logic [1:0] oper,
                      input logic [31:0] a, input logic [31:0] b);
    req_is_div[id]          = dv;
    req_operator[id*2 +: 2] = oper;
    req_signed[id*2 +: 2]   = 2'b00;
    req_op_a[id*32 +: 32]   = a;
    req_op_b[id*32 +: 32]   = b;
    req_valid[id]           = 1'b1;
  endtask

  task automatic expect_op(input logic [1:0] g, input logic [31:0] res, input logic e);
    rsp_t t;
    t.id = g; t.res = res; t.err = e;
    grant_q.push_back(g);
    rsp_q.push_back(t);
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((rsp_q.size() != 0 || busy || req_valid != 2'b00) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_in_time", {31'd0, (n < max)}, 32'd1);
  endtask

  int          n, i0, i1, guard;
  logic [31:0] a0[4]   = '{32'd2, 32'd3, 32'd4, 32'd5};
  logic [31:0] a1[4]   = '{32'd7, 32'd8, 32'd9, 32'd10};
  logic [31:0] res0[4] = '{32'd8, 32'd12, 32'd16, 32'd20};
  logic [31:0] res1[4] = '{32'd21, 32'd24, 32'd27, 32'd30};

  initial begin
    rst = 1'b1; req_valid = '0; req_is_div = '0; req_operator = '0; req_signed = '0;
    req_op_a = '0; req_op_b = '0; flush = '0; rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_en", {30'd0, md_mult_en, md_div_en}, 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    rst = 1'b0;

    // 1: simultaneous requests, req 0 wins first, single-cycle unit
    load(0, 1'b0, 2'd0, 32'd3, 32'd5);
    load(1, 1'b0, 2'd0, 32'd6, 32'd7);
    expect_op(2'b01, 32'd15, 1'b0);
    expect_op(2'b10, 32'd42, 1'b0);
    cycle();
    chk("t1_ready", {30'd0, s_ready}, 32'd1);
    cycle();
    chk("t1_mult_en", {31'd0, s_mult}, 32'd1);
    chk("t1_div_en", {31'd0, s_div}, 32'd0);
    chk("t1_op_a", s_op_a, 32'd3);
    chk("t1_op_b", s_op_b, 32'd5);
    chk("t1_no_rsp_yet", {30'd0, s_rsp_valid}, 32'd0);
    cycle();
    chk("t1_rsp_valid", {30'd0, s_rsp_valid}, 32'd1);
    chk("t1_rsp_result", s_result, 32'd15);
    chk("t1_en_low_resp", {30'd0, s_mult, s_div}, 32'd0);
    drain(50);

    // 2: both requesters continuously busy, grants alternate
    md_lat = 2;
    for (int k = 0; k < 4; k++) begin
      expect_op(2'b01, res0[k], 1'b0);
      expect_op(2'b10, res1[k], 1'b0);
    end
    i0 = 0; i1 = 0; guard = 0;
    while ((i0 < 4 || i1 < 4 || rsp_q.size() != 0 || busy) && guard < 300) begin
      if (!req_valid[0] && i0 < 4) begin load(0, 1'b0, 2'd0, a0[i0], 32'd4); i0++; end
      if (!req_valid[1] && i1 < 4) begin load(1, 1'b0, 2'd0, a1[i1], 32'd3); i1++; end
      cycle();
      guard++;
    end
    chk("t2_in_time", {31'd0, (guard < 300)}, 32'd1);

    // 3: slow divide on requester 1
    md_lat = 6;
    load(1, 1'b1, 2'd2, 32'd100, 32'd7);
    expect_op(2'b10, 32'd14, 1'b0);
    cycle();
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("t3_div_en", {31'd0, s_div}, 32'd1);
      chk("t3_mult_en", {31'd0, s_mult}, 32'd0);
      chk("t3_op_a", s_op_a, 32'd100);
      chk("t3_op_b", s_op_b, 32'd7);
      chk("t3_oper", {30'd0, s_oper}, 32'd2);
      chk("t3_no_rsp", {30'd0, s_rsp_valid}, 32'd0);
    end
    cycle();
    chk("t3_rsp_valid", {30'd0, s_rsp_valid}, 32'd2);
    chk("t3_rsp_result", s_result, 32'd14);
    chk("t3_div_en_low", {31'd0, s_div}, 32'd0);
    drain(50);

    // 4: flush of the owner mid-op, then a clean op
    md_lat = 1; hang = 1'b1;
    load(0, 1'b0, 2'd0, 32'd9, 32'd9);
    grant_q.push_back(2'b01);
    cycle();
    cycle();
    flush = 2'b01;
    cycle();
    flush = 2'b00;
    cycle();
    chk("t4_en_low", {31'd0, s_mult}, 32'd0);
    chk("t4_idle", {31'd0, s_busy}, 32'd0);
    chk("t4_no_rsp", {30'd0, s_rsp_valid}, 32'd0);
    hang = 1'b0;
    load(1, 1'b0, 2'd0, 32'd11, 32'd12);
    expect_op(2'b10, 32'd132, 1'b0);
    drain(50);

    // 5: unit never answers -> watchdog abort; non-owner flush ignored
    hang = 1'b1;
    load(0, 1'b0, 2'd0, 32'd2, 32'd2);
    expect_op(2'b01, 32'd0, 1'b1);
    cycle();
    n = 0;
    for (int k = 0; k < 100; k++) begin
      if (k == 3) flush = 2'b10;
      if (k == 4) flush = 2'b00;
      cycle();
      if (s_mult) n++;
      if (s_rsp_valid != 2'b00) break;
    end
    chk("t5_busy_cycles", n, 32'd64);
    chk("t5_rsp_valid", {30'd0, s_rsp_valid}, 32'd1);
    chk("t5_err", {31'd0, s_err}, 32'd1);
    chk("t5_result", s_result, 32'd0);
    hang = 1'b0;
    drain(50);

    // 6: response back-pressure, then reset during BUSY
    rsp_ready = 2'b00;
    load(1, 1'b0, 2'd0, 32'd4, 32'd5);
    expect_op(2'b10, 32'd20, 1'b0);
    cycle();
    cycle();
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t6_hold_valid", {30'd0, s_rsp_valid}, 32'd2);
      chk("t6_hold_result", s_result, 32'd20);
    end
    rsp_ready = 2'b11;
    cycle();
    cycle();
    chk("t6_idle_after_ack", {31'd0, s_busy}, 32'd0);

    hang = 1'b1;
    load(0, 1'b0, 2'd0, 32'd6, 32'd6);
    grant_q.push_back(2'b01);
    cycle();
    cycle();
    rst = 1'b1;
    #1;
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_en", {30'd0, md_mult_en, md_div_en}, 32'd0);
    chk("t6_rst_op_a", md_op_a, 32'd0);
    chk("t6_rst_outs", {28'd0, rsp_valid, req_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; hang = 1'b0;
    load(0, 1'b0, 2'd0, 32'd7, 32'd8);
    expect_op(2'b01, 32'd56, 1'b0);
    drain(50);
    repeat (3) cycle();

    chk("grant_q_empty", grant_q.size(), 32'd0);
    chk("rsp_q_empty", rsp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
